operand_fetch: RTL and testbench

Reader-side companion to the 8-entry × 8-bit register file. It takes decoded instructions over a valid/ready handshake and drives `srcA`/`srcB` into the register file. It resolves RAW hazards with a per-register outstanding-write scoreboard plus same-cycle writeback bypass, then registers operands and destinations into a one-entry output stage feeding execute. It sits between decode and execute and snoops the register file's M/E write ports.

---
 rtl/operand_fetch_if.sv | 57 +++++
 rtl/operand_fetch.sv | 192 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundle of every handshake and data wire around the operand-fetch stage.
//
// Signal groups
//   decode side   : in_valid, in_ready, in_srcA, in_srcB, in_dstE, in_dstM
//   regfile read  : srcA, srcB (to regfile), A, B (read data back)
//   regfile write : wb_dstM, wb_dstE, wb_M, wb_E (snooped write ports)
//   execute side  : out_valid, out_ready, out_A, out_B, out_dstE, out_dstM
//
// Modports
//   slave  : the operand_fetch block itself
//   master : the environment (decode, register file and execute together)

interface operand_fetch_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_srcA;
  logic [2:0] in_srcB;
  logic [2:0] in_dstE;
  logic [2:0] in_dstM;

  logic [2:0] srcA;
  logic [2:0] srcB;
  logic [7:0] A;
  logic [7:0] B;

  logic [2:0] wb_dstM;
  logic [2:0] wb_dstE;
  logic [7:0] wb_M;
  logic [7:0] wb_E;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_A;
  logic [7:0] out_B;
  logic [2:0] out_dstE;
  logic [2:0] out_dstM;

  modport slave (
    input  in_valid, in_srcA, in_srcB, in_dstE, in_dstM,
    input  A, B,
    input  wb_dstM, wb_dstE, wb_M, wb_E,
    input  out_ready,
    output in_ready,
    output srcA, srcB,
    output out_valid, out_A, out_B, out_dstE, out_dstM
  );

  modport master (
    output in_valid, in_srcA, in_srcB, in_dstE, in_dstM,
    output A, B,
    output wb_dstM, wb_dstE, wb_M, wb_E,
    output out_ready,
    input  in_ready,
    input  srcA, srcB,
    input  out_valid, out_A, out_B, out_dstE, out_dstM
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: reader-side companion to an 8 x 8-bit register file.
//
// Accepts decoded instructions over a valid/ready handshake, drives the register file
// read addresses, resolves RAW hazards with a per-register outstanding-write counter
// and (optionally) a same-cycle writeback bypass, then registers the operands and
// destinations into a one-entry output stage that feeds execute.
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : operand_fetch_if.slave (decode, regfile read/write snoop, execute)
//
// Parameters
//   MAX_OUT : outstanding writes tracked per register (counters are 2 bits wide)
//
// Build option
//   OPFETCH_BYPASS_EN : when defined, a source whose single outstanding write retires
//                       this cycle takes its value from wb_M/wb_E and issues at once.
//                       When undefined, a source must have no outstanding write and
//                       wb_M/wb_E are unused.

module operand_fetch #(
  parameter int unsigned MAX_OUT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_fetch_if.slave bus
);

  localparam logic [1:0] CntMax = 2'(MAX_OUT);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e          state_q;
  logic [7:0][1:0] cnt_q;
  logic [7:0][1:0] cnt_d;
  logic [7:0]      out_a_q;
  logic [7:0]      out_b_q;
  logic [2:0]      out_dste_q;
  logic [2:0]      out_dstm_q;

  logic [7:0] issue_vec;
  logic [7:0] retire_vec;
  logic [7:0] full_vec;
  logic [7:0] pending_vec;

  logic       byp_ok_a;
  logic       byp_ok_b;
  logic [7:0] byp_data_a;
  logic [7:0] byp_data_b;
  logic [8:0] res_a;
  logic [8:0] res_b;

  logic       sat_stall;
  logic       stall;
  logic       in_ready;
  logic       accept;

  // Register file read addresses are straight copies of the decoded sources.
  assign bus.srcA = bus.in_srcA;
  assign bus.srcB = bus.in_srcB;

  // Issue and retire sets. When both ports name the same register it counts once,
  // with the M port taking priority as in the register file.
  always_comb begin
    issue_vec  = '0;
    retire_vec = '0;
    if (bus.in_dstM != 3'd0) begin
      issue_vec[bus.in_dstM] = 1'b1;
    end
    if (bus.in_dstE != 3'd0 && bus.in_dstE != bus.in_dstM) begin
      issue_vec[bus.in_dstE] = 1'b1;
    end
    if (bus.wb_dstM != 3'd0) begin
      retire_vec[bus.wb_dstM] = 1'b1;
    end
    if (bus.wb_dstE != 3'd0 && bus.wb_dstE != bus.wb_dstM) begin
      retire_vec[bus.wb_dstE] = 1'b1;
    end
  end

  always_comb begin
    full_vec    = '0;
    pending_vec = '0;
    for (int i = 1; i < 8; i++) begin
      full_vec[i]    = (cnt_q[i] == CntMax);
      pending_vec[i] = (cnt_q[i] != 2'd0);
    end
  end

`ifdef OPFETCH_BYPASS_EN
  // A register retiring this cycle is written from wb_M if M names it, else wb_E.
  assign byp_ok_a   = retire_vec[bus.in_srcA];
  assign byp_ok_b   = retire_vec[bus.in_srcB];
  assign byp_data_a = (bus.in_srcA == bus.wb_dstM) ? bus.wb_M : bus.wb_E;
  assign byp_data_b = (bus.in_srcB == bus.wb_dstM) ? bus.wb_M : bus.wb_E;
`else
  logic unused_wb_data;

  assign byp_ok_a       = 1'b0;
  assign byp_ok_b       = 1'b0;
  assign byp_data_a     = 8'h00;
  assign byp_data_b     = 8'h00;
  assign unused_wb_data = ^{bus.wb_M, bus.wb_E};
`endif

  // Returns {resolved, operand} for one source.
  function automatic logic [8:0] resolve(input logic [2:0] src,
                                         input logic [1:0] cnt,
                                         input logic       byp_ok,
                                         input logic [7:0] rf_data,
                                         input logic [7:0] byp_data);
    logic [8:0] r;
    if (src == 3'd0) begin
      r = {1'b1, 8'h00};
    end else if (cnt == 2'd0) begin
      r = {1'b1, rf_data};
    end else if (byp_ok && cnt == 2'd1) begin
      r = {1'b1, byp_data};
    end else begin
      r = {1'b0, rf_data};
    end
    return r;
  endfunction

  assign res_a = resolve(bus.in_srcA, cnt_q[bus.in_srcA], byp_ok_a, bus.A, byp_data_a);
  assign res_b = resolve(bus.in_srcB, cnt_q[bus.in_srcB], byp_ok_b, bus.B, byp_data_b);

  // A destination at its counter limit may still issue if one of its writes retires now.
  assign sat_stall = |(issue_vec & full_vec & ~retire_vec);
  assign stall     = !res_a[8] || !res_b[8] || sat_stall;

  // Independent of in_valid so decode can present and withdraw freely.
  assign in_ready     = rst_n && !stall && (state_q == StEmpty || bus.out_ready);
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  // Retiring a register with no outstanding write leaves its counter at zero.
  always_comb begin
    cnt_d = '0;
    for (int i = 1; i < 8; i++) begin
      cnt_d[i] = cnt_q[i]
               + 2'(issue_vec[i] && accept)
               - 2'(retire_vec[i] && pending_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      cnt_q      <= '0;
      out_a_q    <= 8'h00;
      out_b_q    <= 8'h00;
      out_dste_q <= 3'd0;
      out_dstm_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q <= StFull;
          end
        end
        StFull: begin
          if (!accept && bus.out_ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
      // Output data holds after a drain; it only changes on a new accept.
      if (accept) begin
        out_a_q    <= res_a[7:0];
        out_b_q    <= res_b[7:0];
        out_dste_q <= bus.in_dstE;
        out_dstm_q <= bus.in_dstM;
      end
    end
  end

  assign bus.out_valid = (state_q == StFull);
  assign bus.out_A     = out_a_q;
  assign bus.out_B     = out_b_q;
  assign bus.out_dstE  = out_dste_q;
  assign bus.out_dstM  = out_dstm_q;

  // A writeback to a register with nothing outstanding means decode and writeback disagree.
  retire_has_pending: assert property (
    @(posedge clk) disable iff (!rst_n) (retire_vec & ~pending_vec) == 8'h00
  );

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized scoreboard bench for operand_fetch.
// A register-file model drives A/B and commits writebacks. The stimulus process
// predicts in_ready from per-register pending-write counts and, on each accept,
// queues the expected operands (the register's value once this cycle's writeback
// commits). A separate monitor compares the output stage against the queue.

module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif
  localparam int MaxOut = 3;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [2:0] sa;
    logic [2:0] sb;
    logic [2:0] de;
    logic [2:0] dm;
    logic [2:0] wdm;
    logic [2:0] wde;
    logic [7:0] wm;
    logic [7:0] we;
    logic       ordy;
  } stim_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] de;
    logic [2:0] dm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if bus ();

  operand_fetch #(
    .MAX_OUT(MaxOut)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Register file model: r0 holds junk that must never reach the outputs.
  logic [7:0] rf [8] = '{default: 8'hEE};
  assign bus.A = rf[bus.srcA];
  assign bus.B = rf[bus.srcB];
  always @(posedge clk) begin
    if (bus.wb_dstE != 3'd0) rf[bus.wb_dstE] <= bus.wb_E;
    if (bus.wb_dstM != 3'd0) rf[bus.wb_dstM] <= bus.wb_M;
  end

  int   total = 0;
  int   bad = 0;
  bit   chk = 1'b0;
  bit   last_rst = 1'b0;
  bit   exp_full = 1'b0;
  int   pend [8] = '{default: 0};
  exp_t q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit retiring(input logic [2:0] r, input stim_t s);
    return r != 3'd0 && (r == s.wdm || (r == s.wde && s.wde != s.wdm));
  endfunction

  function automatic bit src_ok(input logic [2:0] r, input stim_t s);
    return r == 3'd0 || pend[r] == 0 || (Byp && pend[r] == 1 && retiring(r, s));
  endfunction

  function automatic bit dst_blocked(input logic [2:0] r, input stim_t s);
    return pend[r] == MaxOut && !retiring(r, s);
  endfunction

  function automatic bit exp_ready(input stim_t s);
    bit ok;
    if (s.rst) return 1'b0;
    ok = src_ok(s.sa, s) && src_ok(s.sb, s);
    if (s.dm != 3'd0 && dst_blocked(s.dm, s)) ok = 1'b0;
    if (s.de != 3'd0 && s.de != s.dm && dst_blocked(s.de, s)) ok = 1'b0;
    if (exp_full && !s.ordy) ok = 1'b0;
    return ok;
  endfunction

  // Value register r holds once this cycle's writeback has committed (M wins).
  function automatic logic [7:0] post_wb(input logic [2:0] r, input stim_t s);
    if (r == 3'd0) return 8'h00;
    if (r == s.wdm) return s.wm;
    if (r == s.wde) return s.we;
    return rf[r];
  endfunction

  function automatic stim_t mk(input logic v, input logic [2:0] sa, input logic [2:0] sb,
                               input logic [2:0] de, input logic [2:0] dm,
                               input logic [2:0] wdm, input logic [2:0] wde,
                               input logic [7:0] wm, input logic [7:0] we,
                               input logic ordy);
    stim_t s;
    s = '{rst: 1'b0, v: v, sa: sa, sb: sb, de: de, dm: dm, wdm: wdm, wde: wde,
          wm: wm, we: we, ordy: ordy};
    return s;
  endfunction

  function automatic logic [2:0] pick_pending();
    logic [2:0] c [$];
    for (int r = 1; r < 8; r++) if (pend[r] > 0) c.push_back(3'(r));
    if (c.size() == 0) return 3'd0;
    return c[$urandom_range(c.size() - 1)];
  endfunction

  task automatic step(input stim_t s);
    bit acc;
    @(posedge clk);
    #1;
    if (last_rst && chk) begin
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_A", 32'(bus.out_A), 32'd0);
      check("rst_out_B", 32'(bus.out_B), 32'd0);
      check("rst_out_dstE", 32'(bus.out_dstE), 32'd0);
      check("rst_out_dstM", 32'(bus.out_dstM), 32'd0);
    end
    rst_n         = !s.rst;
    bus.in_valid  = s.v;
    bus.in_srcA   = s.sa;
    bus.in_srcB   = s.sb;
    bus.in_dstE   = s.de;
    bus.in_dstM   = s.dm;
    bus.wb_dstM   = s.wdm;
    bus.wb_dstE   = s.wde;
    bus.wb_M      = s.wm;
    bus.wb_E      = s.we;
    bus.out_ready = s.ordy;
    @(negedge clk);
    #1;
    if (chk) check("in_ready", 32'(bus.in_ready), 32'(exp_ready(s)));
    acc = s.v && (bus.in_ready === 1'b1);
    if (s.rst) begin
      pend     = '{default: 0};
      exp_full = 1'b0;
      q.delete();
    end else begin
      if (acc) begin
        q.push_back('{a: post_wb(s.sa, s), b: post_wb(s.sb, s), de: s.de, dm: s.dm});
        if (s.dm != 3'd0) pend[s.dm]++;
        if (s.de != 3'd0 && s.de != s.dm) pend[s.de]++;
      end
      if (s.wdm != 3'd0 && pend[s.wdm] > 0) pend[s.wdm]--;
      if (s.wde != 3'd0 && s.wde != s.wdm && pend[s.wde] > 0) pend[s.wde]--;
      if (acc) exp_full = 1'b1;
      else if (exp_full && s.ordy) exp_full = 1'b0;
    end
    last_rst = s.rst;
  endtask

  // Monitor: whenever the output stage is presented, compare it with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (chk) begin
        check("out_valid", 32'(bus.out_valid), 32'(exp_full));
        if (bus.out_valid === 1'b1) begin
          if (q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
          end else begin
            check("out_data", 32'({bus.out_A, bus.out_B, bus.out_dstE, bus.out_dstM}),
                  32'(q[0]));
            if (bus.out_ready === 1'b1) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    stim_t s;
    // Preload the register file while in reset; reset ignores these writes.
    s = mk(0, 0, 0, 0, 0, 1, 2, 8'h11, 8'h22, 1); s.rst = 1'b1; step(s);
    s = mk(0, 0, 0, 0, 0, 3, 4, 8'h33, 8'h44, 1); s.rst = 1'b1; step(s);
    s = mk(0, 0, 0, 0, 0, 5, 6, 8'h55, 8'h66, 1); s.rst = 1'b1; step(s);
    s = mk(0, 0, 0, 0, 0, 7, 0, 8'h77, 8'h00, 1); s.rst = 1'b1; step(s);
    chk = 1'b1;
    s = mk(1, 1, 2, 0, 0, 0, 0, 8'h00, 8'h00, 1); s.rst = 1'b1; step(s);

    // No-hazard issue, then RAW on r3 resolved by an E writeback.
    step(mk(1, 1, 2, 3, 0, 0, 0, 8'h00, 8'h00, 1));
    step(mk(1, 3, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1));
    step(mk(1, 3, 0, 0, 0, 0, 3, 8'h00, 8'h5A, 1));
    step(mk(1, 3, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1));
    // M priority when both write ports name r4.
    step(mk(1, 0, 0, 0, 4, 0, 0, 8'h00, 8'h00, 1));
    step(mk(1, 4, 1, 0, 0, 4, 4, 8'hAA, 8'hBB, 1));
    step(mk(1, 4, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1));
    // Saturation on r5.
    repeat (3) step(mk(1, 0, 0, 0, 5, 0, 0, 8'h00, 8'h00, 1));
    step(mk(1, 0, 0, 0, 5, 0, 0, 8'h00, 8'h00, 1));
    step(mk(1, 0, 0, 0, 5, 5, 0, 8'hC3, 8'h00, 1));
    // Backpressure, then drain and refill together.
    repeat (3) step(mk(1, 1, 2, 6, 0, 0, 0, 8'h00, 8'h00, 0));
    step(mk(1, 1, 2, 6, 0, 0, 0, 8'h00, 8'h00, 1));
    step(mk(1, 0, 0, 6, 0, 0, 0, 8'h00, 8'h00, 1));
    // Mid-operation reset with stray writebacks, then a reader of r6 at once.
    s = mk(1, 6, 6, 0, 0, 6, 0, 8'h99, 8'h00, 0); s.rst = 1'b1; step(s);
    step(mk(1, 6, 6, 0, 0, 0, 0, 8'h00, 8'h00, 1));

    for (int n = 0; n < 3000; n++) begin
      s.rst  = ($urandom_range(199) == 0);
      s.v    = ($urandom_range(3) != 0);
      s.sa   = 3'($urandom_range(7));
      s.sb   = 3'($urandom_range(7));
      s.de   = 3'($urandom_range(7));
      s.dm   = 3'($urandom_range(7));
      s.wdm  = $urandom_range(1) ? pick_pending() : 3'd0;
      s.wde  = $urandom_range(1) ? pick_pending() : 3'd0;
      s.wm   = 8'($urandom);
      s.we   = 8'($urandom);
      s.ordy = ($urandom_range(3) != 0);
      step(s);
    end
    repeat (4) step(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
